proc_run_ctrl: RTL

Run controller for the processor top. It drives the `enable` and `finish` inputs of the clock divider from the start/step buttons and the processor's halt flag. It observes the divided processor clock to count executed processor cycles. It supports free-run, single-step and pause, and stops on halt or on a cycle-limit timeout.

---
 rtl/proc_run_ctrl_if.sv | 25 ++
 rtl/proc_run_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/proc_run_ctrl_if.sv
// Signal bundle between the run controller and its surroundings: buttons,
// processor halt flag, divided clock feedback and divider/status outputs.
interface proc_run_ctrl_if;
    logic        start;
    logic        step;
    logic        halt;
    logic        proc_clk;
    logic        enable;
    logic        finish;
    logic        running;
    logic        timeout;
    logic [31:0] cycle_count;

    // Environment side: drives buttons, halt and the divided clock.
    modport master (
        output start, step, halt, proc_clk,
        input  enable, finish, running, timeout, cycle_count
    );

    // Controller side.
    modport slave (
        input  start, step, halt, proc_clk,
        output enable, finish, running, timeout, cycle_count
    );
endinterface

// File: rtl/proc_run_ctrl.sv
// Run controller: turns start/step button presses and the processor halt
// flag into divider enable/finish, counts processor cycles and enforces an
// optional cycle limit.
module proc_run_ctrl #(
    parameter logic [31:0] MAX_CYCLES = 32'd1_000_000
) (
    input  logic          clock,
    input  logic          resetn,
    proc_run_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_STEP,
        ST_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_clear;
    logic        w_set_timeout;

    // [0],[1] synchronise the asynchronous button, [2] holds the previous
    // synchronised value for rise detection.
    logic [2:0]  r_start_sync;
    logic [2:0]  r_step_sync;
    logic        r_pclk_d;

    logic [31:0] r_count;
    logic        r_timeout;
    logic        r_enable;
    logic        r_finish;
    logic        r_running;

    logic        w_start_pulse;
    logic        w_step_pulse;
    logic        w_active;
    logic        w_edge;
    logic [31:0] w_count_next;
    logic        w_limit_hit;

    assign w_start_pulse = r_start_sync[1] & ~r_start_sync[2];
    assign w_step_pulse  = r_step_sync[1]  & ~r_step_sync[2];

    assign w_active     = (r_state == ST_RUN) || (r_state == ST_STEP);
    assign w_edge       = w_active & bus.proc_clk & ~r_pclk_d;
    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    assign w_count_next = (w_edge && (r_count != 32'hFFFF_FFFF)) ? r_count + 32'd1 : r_count;
    // Zero limit disables the timeout entirely.
    assign w_limit_hit  = w_edge && (MAX_CYCLES != 32'd0) && (w_count_next == MAX_CYCLES);

    // Button synchronisers, rise-detect flops and divided-clock history.
    // NOTE: clocked state always uses non-blocking (<=) so every flop samples
    // the pre-edge value of its neighbours, whatever the statement order.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_start_sync <= 3'b000;
            r_step_sync  <= 3'b000;
            r_pclk_d     <= 1'b0;
        end else begin
            r_start_sync <= {r_start_sync[1:0], bus.start};
            r_step_sync  <= {r_step_sync[1:0], bus.step};
            r_pclk_d     <= bus.proc_clk;
        end
    end

    // Next-state decision; halt beats timeout beats edge/step beats start.
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next  = r_state;
        w_clear       = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_step_pulse) begin
                    w_state_next = ST_STEP;
                    w_clear      = 1'b1;
                end else if (w_start_pulse) begin
                    w_state_next = ST_RUN;
                    w_clear      = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.halt) begin
                    w_state_next = ST_DONE;
                end else if (w_limit_hit) begin
                    w_state_next  = ST_DONE;
                    w_set_timeout = 1'b1;
                end else if (w_step_pulse) begin
                    w_state_next = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (w_step_pulse) begin
                    w_state_next = ST_STEP;
                end else if (w_start_pulse) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_STEP: begin
                if (bus.halt) begin
                    w_state_next = ST_DONE;
                end else if (w_limit_hit) begin
                    w_state_next  = ST_DONE;
                    w_set_timeout = 1'b1;
                end else if (w_edge) begin
                    w_state_next = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (w_start_pulse) begin
                    w_state_next = ST_RUN;
                    w_clear      = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register with Moore outputs registered alongside it; the count
    // still takes an edge seen in the cycle the state is left.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_enable  <= 1'b0;
            r_finish  <= 1'b0;
            r_running <= 1'b0;
            r_count   <= 32'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_enable  <= (w_state_next == ST_RUN) || (w_state_next == ST_STEP);
            r_finish  <= (w_state_next == ST_DONE);
            r_running <= (w_state_next == ST_RUN);
            r_count   <= w_clear ? 32'd0 : w_count_next;
            if (w_clear) begin
                r_timeout <= 1'b0;
            end else if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign bus.enable      = r_enable;
    assign bus.finish      = r_finish;
    assign bus.running     = r_running;
    assign bus.timeout     = r_timeout;
    assign bus.cycle_count = r_count;

endmodule
